// File: rtl/mem_lsu_pkg.sv
// Shared types for the data_mem load/store initiator: FSM states, request size codes
// and the alignment rule applied when a request is accepted.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 is reserved and always rejected.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Little-endian lane logic, purely combinational: extracts/extends a load lane from a
// memory word and merges store data into the addressed lane(s) of a memory word.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];

        case (size)
            SZ_B:    load_data = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_H:    load_data = {{16{sgn & half_v[15]}}, half_v};
            default: load_data = word;
        endcase

        store_word = word;
        case (size)
            SZ_B:    store_word[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for word-addressed data_mem: one request in flight, 1 to RD_LAT+3
// cycles to a one-cycle response; req_ready is high only in IDLE, responses cannot stall.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wr,
    output logic                mem_rd,
    output logic [DATA_W-1:0]   mem_wr_data,
    input  logic [DATA_W-1:0]   mem_read_data
);

    localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic        accept;

    logic        q_we;
    logic [1:0]  q_size;
    logic        q_sgn;
    logic [1:0]  q_off;
    logic [31:0] q_wdata;

    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wr_data_n;
    logic              mem_rd_n, mem_wr_n;
    logic              rsp_valid_n, rsp_err_n;
    logic [31:0]       rsp_rdata_n;

    logic [31:0] lane_load, lane_store;

    assign req_ready = rst_n && (state == ST_IDLE);

    // Lanes are computed straight from the memory bus so the last RD edge both
    // captures the read word and produces the load result / merged store word.
    mem_lsu_lane u_lane (
        .word       (mem_read_data),
        .size       (q_size),
        .off        (q_off),
        .sgn        (q_sgn),
        .wdata      (q_wdata),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        accept        = 1'b0;
        mem_addr_n    = mem_addr;
        mem_wr_data_n = mem_wr_data;
        mem_rd_n      = 1'b0;
        mem_wr_n      = 1'b0;
        rsp_valid_n   = 1'b0;
        rsp_err_n     = 1'b0;
        rsp_rdata_n   = '0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    mem_addr_n = req_addr[ADDR_W+1:2];
                    cnt_n      = '0;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_n     = ST_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else if (req_we && (req_size == SZ_W)) begin
                        state_n       = ST_WR;
                        mem_wr_n      = 1'b1;
                        mem_wr_data_n = req_wdata;
                    end else begin
                        state_n  = ST_RD;
                        mem_rd_n = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (cnt == CW'(RD_LAT)) begin
                    if (q_we) begin
                        state_n       = ST_WR;
                        mem_wr_n      = 1'b1;
                        mem_wr_data_n = lane_store;
                    end else begin
                        state_n     = ST_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = lane_load;
                    end
                end else begin
                    cnt_n    = cnt + 1'b1;
                    mem_rd_n = 1'b1;
                end
            end
            ST_WR: begin
                state_n     = ST_RESP;
                rsp_valid_n = 1'b1;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            q_we        <= 1'b0;
            q_size      <= 2'd0;
            q_sgn       <= 1'b0;
            q_off       <= 2'd0;
            q_wdata     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_addr    <= mem_addr_n;
            mem_wr_data <= mem_wr_data_n;
            mem_rd      <= mem_rd_n;
            mem_wr      <= mem_wr_n;
            rsp_valid   <= rsp_valid_n;
            rsp_err     <= rsp_err_n;
            rsp_rdata   <= rsp_rdata_n;
            if (accept) begin
                q_we    <= req_we;
                q_size  <= req_size;
                q_sgn   <= req_signed;
                q_off   <= req_addr[1:0];
                q_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: two instances (RD_LAT=1 and RD_LAT=0), each with its own data_mem
// model; a scoreboard queue per instance is checked by a negedge monitor.
module tb_mem_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_we      [2];
    logic [1:0]  req_size    [2];
    logic        req_signed  [2];
    logic [8:0]  req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic        rsp_valid   [2];
    logic        rsp_err     [2];
    logic [31:0] rsp_rdata   [2];
    logic [6:0]  mem_addr    [2];
    logic        mem_wr      [2];
    logic        mem_rd      [2];
    logic [31:0] mem_wr_data [2];
    logic [31:0] mem_read_data [2];

    mem_lsu #(.ADDR_W(7), .DATA_W(32), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]), .mem_addr(mem_addr[0]),
        .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]), .mem_wr_data(mem_wr_data[0]),
        .mem_read_data(mem_read_data[0])
    );

    mem_lsu #(.ADDR_W(7), .DATA_W(32), .RD_LAT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]), .mem_addr(mem_addr[1]),
        .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]), .mem_wr_data(mem_wr_data[1]),
        .mem_read_data(mem_read_data[1])
    );

    // data_mem models: instance 0 registered read, instance 1 combinational read
    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];
    logic [31:0] rdq0;
    int          wr_cnt [2];
    int          stb_cnt [2];
    logic [6:0]  last_waddr [2];
    logic [31:0] last_wdata [2];
    int          cyc = 0;

    assign mem_read_data[0] = rdq0;
    assign mem_read_data[1] = mem1[mem_addr[1]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr[0] === 1'b1) mem0[mem_addr[0]] <= mem_wr_data[0];
        if (mem_rd[0] === 1'b1) rdq0 <= mem0[mem_addr[0]];
        if (mem_wr[1] === 1'b1) mem1[mem_addr[1]] <= mem_wr_data[1];
        for (int d = 0; d < 2; d++) begin
            if (mem_wr[d] === 1'b1) begin
                wr_cnt[d]     <= wr_cnt[d] + 1;
                last_waddr[d] <= mem_addr[d];
                last_wdata[d] <= mem_wr_data[d];
            end
            if ((mem_wr[d] === 1'b1) || (mem_rd[d] === 1'b1)) stb_cnt[d] <= stb_cnt[d] + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic mon(input int d);
        exp_t e;
        if (mem_rd[d] === 1'b1 && mem_wr[d] === 1'b1) chk("strobe_overlap", 32'd1, 32'd0);
        if (rsp_valid[d] === 1'b1) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_rsp%0d", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rsp_err%0d", d),   {31'd0, rsp_err[d]}, {31'd0, e.err});
                chk($sformatf("rsp_rdata%0d", d), rsp_rdata[d], e.rdata);
                chk($sformatf("rsp_cycle%0d", d), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Drives one request starting just after a posedge; lat<0 means no response expected.
    task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int lat);
        int   n = 0;
        bit   ok = 0;
        exp_t e;
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (req_ready[d] === 1'b1) ok = 1;
            else n++;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else if (lat > 0) begin
            e.err = e_err; e.rdata = e_rd; e.cyc = cyc + lat;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        req_we[d]     = ~we;
        req_size[d]   = 2'd3;
        req_signed[d] = ~sg;
        req_addr[d]   = 9'h1FF;
        req_wdata[d]  = 32'h0;
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        bit ok = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (((d == 0) ? q0.size() : q1.size()) == 0 && req_ready[d] === 1'b1) ok = 1;
            else n++;
        end
        if (!ok) chk("done_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Sequence shared by both latencies: word store, loads, byte RMW, reload.
    task automatic basic_seq(input int d, input int rl);
        int w0;
        w0 = wr_cnt[d];
        issue(d, 1, 2'd2, 0, 9'h090, 32'hDEADBEEF, 0, 32'h0, 2);
        wait_done(d);
        chk("wstore_wrcnt", wr_cnt[d] - w0, 32'd1);
        chk("wstore_addr", {25'd0, last_waddr[d]}, 32'h24);
        chk("wstore_data", last_wdata[d], 32'hDEADBEEF);
        issue(d, 0, 2'd2, 0, 9'h090, 32'h0, 0, 32'hDEADBEEF, 2 + rl);
        issue(d, 0, 2'd0, 1, 9'h093, 32'h0, 0, 32'hFFFFFFDE, 2 + rl);
        issue(d, 0, 2'd0, 0, 9'h093, 32'h0, 0, 32'h000000DE, 2 + rl);
        issue(d, 0, 2'd1, 1, 9'h090, 32'h0, 0, 32'hFFFFBEEF, 2 + rl);
        issue(d, 0, 2'd1, 0, 9'h092, 32'h0, 0, 32'h0000DEAD, 2 + rl);
        issue(d, 0, 2'd0, 1, 9'h091, 32'h0, 0, 32'hFFFFFFBE, 2 + rl);
        issue(d, 0, 2'd1, 1, 9'h092, 32'h0, 0, 32'hFFFFDEAD, 2 + rl);
        wait_done(d);
        w0 = wr_cnt[d];
        issue(d, 1, 2'd0, 0, 9'h091, 32'hAAAAAA55, 0, 32'h0, 3 + rl);
        wait_done(d);
        chk("bstore_wrcnt", wr_cnt[d] - w0, 32'd1);
        chk("bstore_data", last_wdata[d], 32'hDEAD55EF);
        issue(d, 0, 2'd2, 1, 9'h090, 32'h0, 0, 32'hDEAD55EF, 2 + rl);
        wait_done(d);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        int s0, w0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d]      = 1'b0;
            req_valid[d]  = 1'b1;
            req_we[d]     = 1'b1;
            req_size[d]   = 2'd2;
            req_signed[d] = 1'b0;
            req_addr[d]   = 9'h090;
            req_wdata[d]  = 32'h12345678;
            wr_cnt[d]     = 0;
            stb_cnt[d]    = 0;
        end

        // Reset held three cycles with a request pending
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_ready", {31'd0, req_ready[d]}, 32'd0);
                chk("rst_outs", {28'd0, rsp_valid[d], rsp_err[d], mem_wr[d], mem_rd[d]}, 32'd0);
                chk("rst_buses", rsp_rdata[d] | mem_wr_data[d] | {25'd0, mem_addr[d]}, 32'd0);
            end
        end
        chk("rst_strobes", stb_cnt[0] + stb_cnt[1], 32'd0);
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rst_n[d]     = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("ready_after_rst0", {31'd0, req_ready[0]}, 32'd1);
        chk("ready_after_rst1", {31'd0, req_ready[1]}, 32'd1);

        basic_seq(0, 1);

        // Error requests never touch memory
        s0 = stb_cnt[0];
        issue(0, 0, 2'd2, 0, 9'h092, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 2'd1, 0, 9'h091, 32'h00001234, 1, 32'h0, 1);
        issue(0, 0, 2'd3, 1, 9'h090, 32'h0, 1, 32'h0, 1);
        wait_done(0);
        chk("err_no_strobes", stb_cnt[0] - s0, 32'd0);
        chk("err_mem_intact", mem0[36], 32'hDEAD55EF);

        // Reset during the RD phase of a byte RMW
        w0 = wr_cnt[0];
        issue(0, 1, 2'd0, 0, 9'h090, 32'h00000011, 0, 32'h0, -1);
        rst_n[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", {30'd0, mem_rd[0], mem_wr[0]}, 32'd0);
        chk("abort_ready", {31'd0, req_ready[0]}, 32'd0);
        rst_n[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_write", wr_cnt[0] - w0, 32'd0);
        chk("abort_mem_intact", mem0[36], 32'hDEAD55EF);
        chk("abort_ready_back", {31'd0, req_ready[0]}, 32'd1);

        basic_seq(1, 0);
        issue(1, 1, 2'd1, 0, 9'h092, 32'hFFFF1234, 0, 32'h0, 3);
        issue(1, 0, 2'd2, 0, 9'h090, 32'h0, 0, 32'h123455EF, 2);
        wait_done(1);
        chk("half_store_mem", mem1[36], 32'h123455EF);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator for the word-addressed `data_mem`, i.e. the requesting side of the `clk/addr/mem_wr/mem_rd/wr_data/read_data` interface.
- Accepts byte, halfword and word requests from the pipeline on a valid/ready handshake.
- Turns them into `data_mem` read and write cycles; sub-word stores use read-modify-write.
- Returns one response per request: load data sign- or zero-extended, or an error flag.

Parameters:
- ADDR_W, 7, word-address width driven to `data_mem`. Byte address width is ADDR_W+2.
- DATA_W, 32, data width. Fixed at 32; other values unsupported.
- RD_LAT, 1, `data_mem` read latency in cycles: 0 = combinational read, 1 = data valid after the edge that samples mem_rd.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE with rst_n=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  misaligned or reserved-size request; qualified by rsp_valid
- rsp_rdata  out  32  load result; 0 for stores and errors
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wr  out  1  write strobe to `data_mem`
- mem_rd  out  1  read strobe to `data_mem`
- mem_wr_data  out  32  write data to `data_mem`
- mem_read_data  in  32  read data from `data_mem`

Behaviour:
- **Reset.** Clock is clk; reset is rst_n, synchronous, active-low. While rst_n=0 at an edge: state=IDLE and all registered outputs = 0 (rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wr, mem_rd, mem_wr_data). req_ready is 0 while rst_n=0.
- **Abort.** Reset mid-operation aborts. mem_wr/mem_rd are low from the cycle after the reset edge. No response is issued. An aborted read-modify-write leaves memory unmodified.
- **States:** IDLE, RD, WR, RESP.
- **Accept.** A request is accepted in cycle N when req_valid & req_ready at the end of cycle N. All request fields are latched at that edge; later changes on request inputs are ignored.
- **Alignment check (at accept):**
  - half with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error;
  - size=3 is an error.
  - On error: IDLE->RESP, no memory access, rsp_err=1, rsp_valid in cycle N+1.
- **Word store:** IDLE->WR->RESP.
  - WR (cycle N+1): mem_wr=1, mem_wr_data=req_wdata.
  - rsp_valid in N+2.
- **Load:** IDLE->RD->RESP.
  - RD lasts RD_LAT+1 cycles (N+1..N+1+RD_LAT). mem_rd=1 and mem_addr stable throughout.
  - mem_read_data is captured at the edge ending the last RD cycle.
  - rsp_valid in N+2+RD_LAT.
- **Sub-word store:** IDLE->RD->WR->RESP.
  - RD as for a load.
  - WR writes the merged word: only the addressed lane(s) are replaced by req_wdata[7:0] or [15:0].
  - rsp_valid in N+3+RD_LAT.
- **Byte lanes.** Little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half lane = addr[1].
- **Load extraction.** Lane is right-justified. Zero-extended if req_signed=0, else sign-extended from bit 7 or bit 15. Word loads ignore req_signed.
- **Strobes.** mem_rd and mem_wr are never high in the same cycle. Both are low in IDLE and RESP.
- **Response.** RESP lasts exactly 1 cycle: rsp_valid=1, then IDLE. There is no response backpressure. req_ready returns high in the cycle after RESP, so the maximum rate is one word store per 3 cycles.

Decomposition:
- **mem_lsu_pkg:**
  - state encoding (IDLE, RD, WR, RESP);
  - size codes SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - function for the misalignment check.
- **mem_lsu_lane** (combinational sub-module): load extract/extend and store merge, from (word, size, addr[1:0], signed, wdata).
- mem_lsu holds the FSM, the RD_LAT counter and the request/response registers.

Test Plan:
1. Reset: hold rst_n=0 three cycles with req_valid=1 -> req_ready=0, all outputs 0, no mem_rd/mem_wr. Release -> req_ready=1 next cycle.
2. Word store then load: store addr=0x090 (word 0x24), data=0xDEADBEEF -> mem_wr one cycle, mem_addr=0x24, mem_wr_data=0xDEADBEEF. Then load word at 0x090 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at N+3 with RD_LAT=1.
3. Byte loads from word 0xDEADBEEF:
   - addr 0x093, signed -> 0xFFFFFFDE;
   - unsigned -> 0x000000DE;
   - addr 0x090 half signed -> 0xFFFFBEEF.
4. Sub-word store: store byte 0x55 at 0x091 -> one read then write of 0xDEAD55EF to word 0x24, rsp_valid at N+4.
5. Misaligned: word load at 0x092, half store at 0x091, size=3 -> rsp_err=1 at N+1, rsp_rdata=0, mem_rd/mem_wr never asserted, memory unchanged.
6. Reset mid-RMW: byte store to 0x090, assert rst_n=0 during RD -> no mem_wr, no rsp_valid, word 0x24 still 0xDEAD55EF. Repeat tests 2–4 with RD_LAT=0 and latencies reduced by 1.
